// File: rtl/pool2x2_ctrl.sv
// Streaming 2x2 max-pool controller: buffers one row, forms non-overlapping windows, and emits one pooled pixel per window.
// Defining POOL_RELU_EN fuses a ReLU: negative results are replaced by zero before the output register.

module max_pool #(
    parameter int DATA_SIZE = 16
) (
    input  logic [4*DATA_SIZE-1:0] din,
    output logic [DATA_SIZE-1:0]   dout
);
    logic signed [DATA_SIZE-1:0] w_a, w_b, w_c, w_d, w_ab, w_cd;

    assign w_a  = din[4*DATA_SIZE-1 -: DATA_SIZE];
    assign w_b  = din[3*DATA_SIZE-1 -: DATA_SIZE];
    assign w_c  = din[2*DATA_SIZE-1 -: DATA_SIZE];
    assign w_d  = din[DATA_SIZE-1 -: DATA_SIZE];
    assign w_ab = (w_a > w_b) ? w_a : w_b;
    assign w_cd = (w_c > w_d) ? w_c : w_d;
    assign dout = (w_ab > w_cd) ? w_ab : w_cd;
endmodule

module pool2x2_ctrl #(
    parameter int DATA_SIZE = 16,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] out_data,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_POOL,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state, w_next;
    logic [DATA_SIZE-1:0]  r_linebuf [IMG_W];
    logic [DATA_SIZE-1:0]  r_prev;
    logic [DATA_SIZE-1:0]  r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_out_hs;
    logic                  w_load;
    logic                  w_col_last;
    logic                  w_row_last;
    logic [CW-1:0]         w_col_m1;
    logic [DATA_SIZE-1:0]  w_max;
    logic [DATA_SIZE-1:0]  w_pooled;

    assign w_in_ready = (r_state == S_FILL) ||
                        ((r_state == S_POOL) && (!r_out_valid || out_ready));
    assign w_accept   = in_valid && w_in_ready;
    assign w_out_hs   = r_out_valid && out_ready;
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));
    assign w_col_m1   = r_col - CW'(1);
    assign w_load     = (r_state == S_POOL) && w_accept && r_col[0];

    max_pool #(.DATA_SIZE(DATA_SIZE)) u_max_pool (
        .din  ({r_linebuf[w_col_m1], r_linebuf[r_col], r_prev, in_data}),
        .dout (w_max)
    );

`ifdef POOL_RELU_EN
    assign w_pooled = w_max[DATA_SIZE-1] ? '0 : w_max;
`else
    assign w_pooled = w_max;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_FILL;
            S_FILL:  if (w_accept && w_col_last) w_next = S_POOL;
            S_POOL:  if (w_accept && w_col_last) w_next = w_row_last ? S_DRAIN : S_FILL;
            S_DRAIN: if (w_out_hs) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Counters move only on accepted pixels; the row counter tracks even (fill) / odd (pool) rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && (r_state == S_FILL)) r_linebuf[r_col] <= in_data;
        if (w_accept && (r_state == S_POOL) && !r_col[0]) r_prev <= in_data;
    end

    // Single-entry output register; a reload in the same cycle as a drain keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_pooled;
            r_out_last  <= w_row_last && w_col_last;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
endmodule

// File: tb/tb_pool2x2_ctrl.sv
// Self-checking bench for pool2x2_ctrl: table of 4x4 frames with hand-computed results,
// reset/idle corner sequences, and a random 28x28 frame against a behavioural model.

module tb_pool2x2_ctrl;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        start = 1'b0;
   logic        inValid = 1'b0;
   logic [15:0] inData = '0;
   logic        outReady = 1'b0;
   logic        sel = 1'b0;

   logic        aInReady, aOutValid, aOutLast, aBusy, aDone;
   logic [15:0] aOutData;
   logic        bInReady, bOutValid, bOutLast, bBusy, bDone;
   logic [15:0] bOutData;

   logic        inReady, outValid, outLast, busy, done;
   logic [15:0] outData;

   int tests = 0;
   int failures = 0;
   int curW = 4;
   logic [15:0] curPx[$];
   logic [15:0] curExp[$];

   always #5 clk = ~clk;

   pool2x2_ctrl #(.DATA_SIZE(16), .IMG_W(4), .IMG_H(4)) dutA (
      .clk(clk), .rst_n(rstN), .start(start && !sel), .in_valid(inValid && !sel),
      .in_data(inData), .in_ready(aInReady), .out_valid(aOutValid), .out_data(aOutData),
      .out_ready(outReady && !sel), .out_last(aOutLast), .busy(aBusy), .done(aDone)
   );

   pool2x2_ctrl #(.DATA_SIZE(16), .IMG_W(28), .IMG_H(28)) dutB (
      .clk(clk), .rst_n(rstN), .start(start && sel), .in_valid(inValid && sel),
      .in_data(inData), .in_ready(bInReady), .out_valid(bOutValid), .out_data(bOutData),
      .out_ready(outReady && sel), .out_last(bOutLast), .busy(bBusy), .done(bDone)
   );

   assign inReady  = sel ? bInReady  : aInReady;
   assign outValid = sel ? bOutValid : aOutValid;
   assign outData  = sel ? bOutData  : aOutData;
   assign outLast  = sel ? bOutLast  : aOutLast;
   assign busy     = sel ? bBusy     : aBusy;
   assign done     = sel ? bDone     : aDone;

`ifdef POOL_RELU_EN
   localparam logic [15:0] EXP_NEG1 = 16'h0000;
   localparam logic [15:0] EXP_8003 = 16'h0000;
`else
   localparam logic [15:0] EXP_NEG1 = 16'hFFFF;
   localparam logic [15:0] EXP_8003 = 16'h8003;
`endif

   typedef struct {
      logic [15:0] px [16];
      logic [15:0] ex [4];
      int          bp;
      bit          midStart;
      string       name;
   } vec_t;

   vec_t vecs [5];

   // One comparison: counts it, and reports it when actual and expected differ.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] smax(input logic [15:0] x, input logic [15:0] y);
      return ($signed(x) > $signed(y)) ? x : y;
   endfunction

   function automatic logic [15:0] refPool(input logic [15:0] a, b, c, d);
      logic [15:0] m;
      m = smax(smax(a, b), smax(c, d));
`ifdef POOL_RELU_EN
      if (m[15]) m = 16'h0000;
`endif
      return m;
   endfunction

   // Runs one frame on the selected DUT. bp: 0 = always ready, 1 = hold 3 cycles per output, 2 = random.
   task automatic applyStimulus(input int bp, input bit midStart, input string name);
      int n, k, cyc, waitCnt, firstCyc, lastCyc, budget, total;
      bit lastHs, expV, doneSeen, inHs, outHs;
      total = curPx.size();
      budget = 20 * total + 200;
      n = 0; k = 0; cyc = 0; waitCnt = 0; firstCyc = 0; lastCyc = 0;
      lastHs = 0; expV = 0; doneSeen = 0;

      @(negedge clk);
      start = 1'b1;
      inValid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      #1;
      checkOutput({name, "_busy_start"}, busy, 1);
      checkOutput({name, "_fill_ready"}, inReady, 1);

      while (!doneSeen && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (lastHs) begin
            checkOutput({name, "_done_pulse"}, done, 1);
            doneSeen = 1;
            break;
         end
         if (done) checkOutput({name, "_done_early"}, done, 0);
         if (expV) checkOutput({name, "_latency"}, outValid, 1);

         if (bp == 0) outReady = 1'b1;
         else if (bp == 1) begin
            if (outValid) begin
               waitCnt++;
               outReady = (waitCnt > 3);
            end else outReady = 1'b1;
         end else outReady = 1'($urandom_range(0, 1));

         start = midStart && (n == 5);
         inValid = (n < total);
         inData = (n < total) ? curPx[n] : 16'h0;
         #1;

         inHs = inValid && inReady;
         outHs = outValid && outReady;
         if (n < total && outValid && !outReady) begin
            if (((n / curW) % 2) == 1) checkOutput({name, "_in_blocked"}, inReady, 0);
            else checkOutput({name, "_in_fill"}, inReady, 1);
         end
         if (outHs) begin
            if (k < curExp.size()) begin
               checkOutput($sformatf("%s_data%0d", name, k), outData, curExp[k]);
               checkOutput($sformatf("%s_last%0d", name, k), outLast, (k == curExp.size() - 1));
            end else checkOutput({name, "_extra_output"}, k, curExp.size() - 1);
            k++;
            waitCnt = 0;
         end
         lastHs = outHs && outLast;
         expV = inHs && (((n / curW) % 2) == 1) && ((n % curW) % 2 == 1);
         if (inHs) begin
            n++;
            if (n == 1) firstCyc = cyc;
            if (n == total) lastCyc = cyc;
         end
      end
      start = 1'b0;
      inValid = 1'b0;
      outReady = 1'b0;

      if (!doneSeen) checkOutput({name, "_timeout"}, cyc, budget - 1);
      checkOutput({name, "_in_count"}, n, total);
      checkOutput({name, "_out_count"}, k, curExp.size());
      if (bp == 0) checkOutput({name, "_throughput"}, lastCyc - firstCyc + 1, total);
      @(negedge clk);
      #1;
      checkOutput({name, "_done_clear"}, done, 0);
      checkOutput({name, "_idle"}, busy, 0);
   endtask

   task automatic loadVec(input int i);
      curPx.delete();
      curExp.delete();
      foreach (vecs[i].px[j]) curPx.push_back(vecs[i].px[j]);
      foreach (vecs[i].ex[j]) curExp.push_back(vecs[i].ex[j]);
   endtask

   initial begin
      // Vector table: 4x4 frames in raster order with hand-computed pooled outputs.
      for (int j = 0; j < 16; j++) vecs[0].px[j] = 16'(j);
      vecs[0].ex = '{16'd5, 16'd7, 16'd13, 16'd15};
      vecs[0].bp = 0; vecs[0].midStart = 0; vecs[0].name = "ramp";
      vecs[1] = vecs[0];
      vecs[1].bp = 1; vecs[1].name = "ramp_bp";
      vecs[2].px = '{16'hFFFD, 16'hFFFF, 16'h0000, 16'h0000,
                     16'hFFF8, 16'hFFFE, 16'h0000, 16'h0000,
                     16'h0000, 16'h0000, 16'h0000, 16'h0000,
                     16'h0000, 16'h0000, 16'h0000, 16'h0000};
      vecs[2].ex = '{EXP_NEG1, 16'h0000, 16'h0000, 16'h0000};
      vecs[2].bp = 0; vecs[2].midStart = 0; vecs[2].name = "neg";
      vecs[3].px = '{16'h7FFF, 16'h8000, 16'h8000, 16'h8001,
                     16'h0001, 16'hFFFF, 16'h8002, 16'h8003,
                     16'h0010, 16'h0020, 16'hFFF0, 16'h0005,
                     16'h0030, 16'h0040, 16'h8000, 16'h7FFF};
      vecs[3].ex = '{16'h7FFF, EXP_8003, 16'h0040, 16'h7FFF};
      vecs[3].bp = 0; vecs[3].midStart = 0; vecs[3].name = "mixed";
      vecs[4] = vecs[0];
      vecs[4].midStart = 1; vecs[4].name = "mid_start";

      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_out_valid", outValid, 0);
      checkOutput("reset_out_data", outData, 0);
      checkOutput("reset_in_ready", inReady, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_out_last", outLast, 0);
      @(negedge clk);
      rstN = 1'b1;

      // Pixels offered while idle must not be consumed.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         inValid = 1'b1;
         inData = 16'hAAAA;
         #1;
         checkOutput("idle_in_ready", inReady, 0);
         checkOutput("idle_busy", busy, 0);
      end
      inValid = 1'b0;

      for (int i = 0; i < 5; i++) begin
         loadVec(i);
         applyStimulus(vecs[i].bp, vecs[i].midStart, vecs[i].name);
      end

      // Reset after six pixels: the pending window is discarded and the next frame starts clean.
      loadVec(0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      outReady = 1'b0;
      begin
         int n;
         n = 0;
         for (int c = 0; c < 50 && n < 6; c++) begin
            @(negedge clk);
            inValid = 1'b1;
            inData = curPx[n];
            #1;
            if (inReady) n++;
         end
      end
      @(negedge clk);
      inValid = 1'b0;
      #1;
      checkOutput("pre_reset_valid", outValid, 1);
      checkOutput("pre_reset_data", outData, 16'd5);
      rstN = 1'b0;
      #1;
      checkOutput("rst_out_valid", outValid, 0);
      checkOutput("rst_out_data", outData, 0);
      checkOutput("rst_in_ready", inReady, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(0, 0, "after_reset");

      // Full-size frame with random data and random backpressure against the model.
      sel = 1'b1;
      curW = 28;
      curPx.delete();
      curExp.delete();
      for (int j = 0; j < 28 * 28; j++) curPx.push_back(16'($urandom));
      for (int r = 0; r < 14; r++)
         for (int c = 0; c < 14; c++)
            curExp.push_back(refPool(curPx[(2*r)*28 + 2*c], curPx[(2*r)*28 + 2*c + 1],
                                     curPx[(2*r+1)*28 + 2*c], curPx[(2*r+1)*28 + 2*c + 1]));
      applyStimulus(2, 0, "rand28");

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/pool2x2_ctrl.md
# pool2x2_ctrl

Streaming controller that sequences the shared 2x2 max comparator (`max_pool`) across one feature map. It accepts a raster-order pixel stream, buffers one row, and assembles each non-overlapping 2x2 window. Each window goes through the comparator, and one pooled pixel per window is emitted on a registered valid/ready output. It sits between a convolution layer's output stream and the next layer's input (e.g. C1 28x28 -> S2 14x14).

## Interface
- `DATA_SIZE`, 16: pixel width, two's-complement fixed point.
- `IMG_W`, 28: input width; even, >= 2.
- `IMG_H`, 28: input height; even, >= 2.
- `clk`  input  1  clock, rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `start`  input  1  one-cycle pulse; begins a frame when idle.
- `in_valid`  input  1  input pixel valid.
- `in_data`  input  DATA_SIZE  input pixel.
- `in_ready`  output  1  controller accepts `in_data` this cycle.
- `out_valid`  output  1  pooled pixel valid.
- `out_data`  output  DATA_SIZE  pooled pixel.
- `out_ready`  input  1  downstream accepts `out_data`.
- `out_last`  output  1  marks the final pooled pixel of the frame; qualified by `out_valid`.
- `busy`  output  1  frame in progress.
- `done`  output  1  one-cycle pulse at end of frame.

## Operation
- Instantiates `max_pool`. Window packing on its `din` (MSB to LSB):
  - top-left = `linebuf[col-1]`
  - top-right = `linebuf[col]`
  - bottom-left = `prev`
  - bottom-right = current `in_data`
- Storage:
  - `linebuf`: IMG_W entries x DATA_SIZE.
  - `prev`: one-pixel register.
  - `col` counter: 0..IMG_W-1.
  - `row` counter: 0..IMG_H-1.
- FSM states:
  - IDLE: `in_ready`=0. `start` -> FILL; `row` and `col` cleared.
  - FILL (even row): each accepted pixel is written to `linebuf[col]`. At `col`=IMG_W-1, `col` wraps to 0 and the state goes to POOL.
  - POOL (odd row):
    - Even `col`: the accepted pixel goes into `prev`.
    - Odd `col`: the accepted pixel completes the window; the comparator result is loaded into the output register and `out_valid`=1.
    - At `col`=IMG_W-1: if `row`=IMG_H-1, go to DRAIN; otherwise go to FILL.
  - DRAIN: wait for the final output handshake, then go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `in_ready`:
  - FILL: 1.
  - POOL: `!out_valid || out_ready`.
  - Otherwise: 0.
- A pixel is accepted on `in_valid && in_ready`. Counters advance only on acceptance.
- Output register: loaded on acceptance at odd row / odd col. Cleared (`out_valid`=0) on `out_valid && out_ready` unless reloaded in the same cycle.
- `out_last` = 1 when the loaded window is at `row`=IMG_H-1, `col`=IMG_W-1.
- `busy` = 1 in every state except IDLE.
- Comparison is signed. Equal values: any equal operand may be selected, since the result value is identical.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counters 0. `linebuf` contents need not be reset.
- Latency: `out_valid` rises the cycle after the window's bottom-right pixel is accepted.
- Throughput: one pixel per cycle with no backpressure. The output register is single-entry; in a POOL row, a full unaccepted output register blocks input.
- Simultaneous drain and load: output handshake and new window load in the same cycle give `out_valid` staying 1 with the new data.
- `start` while `busy`=1: ignored. `in_valid` in IDLE, DRAIN or DONE: ignored, not consumed.
- `done` asserts the cycle after the handshake of the `out_last` pixel.
- `rst_n` low mid-frame: immediate return to IDLE; a pending output is discarded.
- Output count per frame: exactly (IMG_W/2)*(IMG_H/2).

## Configuration
- `POOL_RELU_EN`:
  - Defined: a result with its sign bit set is replaced by 0 before the output register (fused ReLU).
  - Undefined: the comparator result passes unmodified.

## Test plan
- IMG_W=IMG_H=4, input 0..15 raster, no backpressure -> outputs 5, 7, 13, 15. `out_last` on 15. `done` one cycle after its handshake. 16 input cycles.
- Same frame, `out_ready` low for 3 cycles after each `out_valid` -> identical output sequence, no lost or duplicated pixels, `in_ready` low while the register is held.
- Window {-3, -1, -8, -2} (0xFFFD, 0xFFFF, 0xFFF8, 0xFFFE) -> 0xFFFF without `POOL_RELU_EN`; 0x0000 with it.
- Mixed signs {0x7FFF, 0x8000, 0x0001, 0xFFFF} -> 0x7FFF.
- `start` pulsed mid-frame -> ignored, counters unaffected. `rst_n` low after 6 input pixels -> all outputs 0 and IDLE. A new frame after `start` produces the correct 4 results.
- Default 28x28 frame, random data, random `out_ready` -> 196 outputs matching the reference model. `out_last` only on the 196th.
